// File: rtl/udsp_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : udsp_frame_sequencer
// Description : Runs the uDSP core for one program pass per audio sample and
//               arbitrates the data-memory write port between the core and a
//               buffered host coefficient-write path.
//
//   The core is held in reset-like start (core_start=1) while idle. Each
//   sample_tick releases it for PROG_LEN+DRAIN cycles, then one DONE cycle
//   pulses frame_done. A tick arriving while a pass is in flight is remembered
//   once (pending); further ticks are dropped and counted in overrun_cnt.
//
//   While the core runs it owns the W port combinationally. In every other
//   state the host FIFO drains one entry per cycle onto the W port.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   sample_tick     : one-cycle pulse per audio sample
//   core_start      : start/clear to the uDSP core (1 = held at PC 0)
//   core_addrW/dataW/we : core W-port request
//   host_valid/ready/addr/data : host write handshake into the FIFO
//   mem_addrW/dataW/we : data memory W port
//   busy            : pass in progress (RUN or DONE)
//   frame_done      : one-cycle pulse at the end of each pass
//   overrun_cnt     : saturating count of dropped sample ticks
//
// Revision    : 1.0 - initial release
// ============================================================================
module udsp_frame_sequencer #(
   parameter int PROG_LEN   = 384,
   parameter int DRAIN      = 3,
   parameter int DAW        = 10,
   parameter int DWW        = 36,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           sample_tick,
   output logic           core_start,
   input  logic [DAW-1:0] core_addrW,
   input  logic [DWW-1:0] core_dataW,
   input  logic           core_we,
   input  logic           host_valid,
   output logic           host_ready,
   input  logic [DAW-1:0] host_addr,
   input  logic [DWW-1:0] host_data,
   output logic [DAW-1:0] mem_addrW,
   output logic [DWW-1:0] mem_dataW,
   output logic           mem_we,
   output logic           busy,
   output logic           frame_done,
   output logic [15:0]    overrun_cnt
);

   localparam int               PASS_LEN = PROG_LEN + DRAIN;
   localparam int               CNT_W    = $clog2(PASS_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PASS_LEN - 1);
   localparam int               PTR_W    = $clog2(FIFO_DEPTH);
   localparam int               ENT_W    = DAW + DWW;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             pending;

   // ------------------------------------------------------------------------
   // Host write FIFO. Pointers carry one extra wrap bit so full and empty are
   // distinguishable without a separate occupancy counter.
   // ------------------------------------------------------------------------
   logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic             pop;
   logic [ENT_W-1:0] fifo_head;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign host_ready = ~fifo_full;
   assign push       = host_valid & host_ready;
   // The core owns the port for the whole pass, so draining pauses in RUN.
   assign pop        = (state != ST_RUN) & ~fifo_empty;
   assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: emptiness is defined by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {host_addr, host_data};
   end

   // ------------------------------------------------------------------------
   // W-port mux
   // ------------------------------------------------------------------------
   always_comb begin
      mem_we    = 1'b0;
      mem_addrW = '0;
      mem_dataW = '0;
      if (state == ST_RUN) begin
         mem_we    = core_we;
         mem_addrW = core_addrW;
         mem_dataW = core_dataW;
      end else begin
         mem_we    = ~fifo_empty;
         mem_addrW = fifo_head[ENT_W-1:DWW];
         mem_dataW = fifo_head[DWW-1:0];
      end
   end

   // ------------------------------------------------------------------------
   // Pass sequencer
   // A tick is dropped whenever one is already pending, including the IDLE
   // cycle that consumes the pending request, so the overrun test does not
   // depend on state.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         core_start  <= 1'b1;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         pending     <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         frame_done <= 1'b0;

         if (sample_tick && pending && (overrun_cnt != 16'hFFFF))
            overrun_cnt <= overrun_cnt + 16'd1;

         if ((state != ST_IDLE) && sample_tick && !pending)
            pending <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (sample_tick || pending) begin
                  state      <= ST_RUN;
                  cnt        <= '0;
                  core_start <= 1'b0;
                  busy       <= 1'b1;
                  pending    <= 1'b0;
               end
            end
            ST_RUN: begin
               if (cnt == CNT_LAST) begin
                  state      <= ST_DONE;
                  core_start <= 1'b1;
                  frame_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state      <= ST_IDLE;
               core_start <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_udsp_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_udsp_frame_sequencer
// Description : Self-checking bench for udsp_frame_sequencer with a short
//               program (PROG_LEN=8, DRAIN=3) so a full pass is 11 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udsp_frame_sequencer;

   localparam int PROG_LEN = 8;
   localparam int DRAIN    = 3;
   localparam int DAW      = 10;
   localparam int DWW      = 36;
   localparam int NVEC     = 20;

   logic           clk = 1'b0;
   logic           rst;
   logic           sample_tick;
   logic           core_start;
   logic [DAW-1:0] core_addrW;
   logic [DWW-1:0] core_dataW;
   logic           core_we;
   logic           host_valid;
   logic           host_ready;
   logic [DAW-1:0] host_addr;
   logic [DWW-1:0] host_data;
   logic [DAW-1:0] mem_addrW;
   logic [DWW-1:0] mem_dataW;
   logic           mem_we;
   logic           busy;
   logic           frame_done;
   logic [15:0]    overrun_cnt;

   int tests  = 0;
   int fails  = 0;

   udsp_frame_sequencer #(
      .PROG_LEN  (PROG_LEN),
      .DRAIN     (DRAIN),
      .DAW       (DAW),
      .DWW       (DWW),
      .FIFO_DEPTH(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sample_tick(sample_tick),
      .core_start (core_start),
      .core_addrW (core_addrW),
      .core_dataW (core_dataW),
      .core_we    (core_we),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .host_addr  (host_addr),
      .host_data  (host_data),
      .mem_addrW  (mem_addrW),
      .mem_dataW  (mem_dataW),
      .mem_we     (mem_we),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic           tick;
      logic           cwe;
      logic [DAW-1:0] caddr;
      logic [DWW-1:0] cdata;
      logic           hvalid;
      logic [DAW-1:0] haddr;
      logic [DWW-1:0] hdata;
      logic           e_start;
      logic           e_busy;
      logic           e_done;
      logic           e_we;
      logic           e_ready;
      logic [DAW-1:0] e_addr;
      logic [DWW-1:0] e_data;
   } vec_t;

   vec_t vecs [NVEC];

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      sample_tick = 1'b0;
      core_we     = 1'b0;
      core_addrW  = '0;
      core_dataW  = '0;
      host_valid  = 1'b0;
      host_addr   = '0;
      host_data   = '0;
   endtask

   initial begin
      int       fd;
      logic     ok;
      logic [63:0] act;
      logic [63:0] exp;

      // ---------------- vector table ----------------
      // Cycle-relative timeline: tick at t=2 -> RUN t=3..13, DONE t=14.
      // Host pushes 0x100..0x103 at t=6..9 (FIFO full from t=10), 0x104 held
      // until accepted at t=15. Drain: t=14..18 in host order.
      for (int t = 0; t < NVEC; t++) begin
         vecs[t].tick    = 1'b0;
         vecs[t].cwe     = 1'b0;
         vecs[t].caddr   = '0;
         vecs[t].cdata   = '0;
         vecs[t].hvalid  = 1'b0;
         vecs[t].haddr   = '0;
         vecs[t].hdata   = '0;
         vecs[t].e_start = !(t >= 3 && t <= 13);
         vecs[t].e_busy  = (t >= 3 && t <= 14);
         vecs[t].e_done  = (t == 14);
         vecs[t].e_ready = !(t >= 10 && t <= 14);
         vecs[t].e_we    = 1'b0;
         vecs[t].e_addr  = '0;
         vecs[t].e_data  = '0;
      end
      vecs[2].tick = 1'b1;
      // Core write in IDLE must not reach memory.
      vecs[1].cwe = 1'b1; vecs[1].caddr = 10'h3FF; vecs[1].cdata = 36'hF_FFFF_FFFF;
      // Core write in RUN passes through the same cycle.
      vecs[5].cwe = 1'b1; vecs[5].caddr = 10'h012; vecs[5].cdata = 36'h1_2345_6789;
      vecs[5].e_we = 1'b1; vecs[5].e_addr = 10'h012; vecs[5].e_data = 36'h1_2345_6789;
      // Core write in DONE ignored; the FIFO head drains instead.
      vecs[14].cwe = 1'b1; vecs[14].caddr = 10'h3AA; vecs[14].cdata = 36'h5_5555_5555;
      for (int k = 0; k < 4; k++) begin
         vecs[6+k].hvalid = 1'b1;
         vecs[6+k].haddr  = 10'h100 + 10'(k);
         vecs[6+k].hdata  = 36'hA_0000_0000 + 36'(k);
      end
      for (int t = 10; t <= 15; t++) begin
         vecs[t].hvalid = 1'b1;
         vecs[t].haddr  = 10'h104;
         vecs[t].hdata  = 36'hA_0000_0004;
      end
      for (int t = 14; t <= 18; t++) begin
         vecs[t].e_we   = 1'b1;
         vecs[t].e_addr = 10'h100 + 10'(t - 14);
         vecs[t].e_data = 36'hA_0000_0000 + 36'(t - 14);
      end

      // ---------------- reset ----------------
      idle_inputs();
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      repeat (10) cyc();
      chk("reset_state",
          {43'd0, core_start, busy, frame_done, mem_we, host_ready, overrun_cnt},
          {43'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0});

      // ---------------- table ----------------
      for (int t = 0; t < NVEC; t++) begin
         sample_tick = vecs[t].tick;
         core_we     = vecs[t].cwe;
         core_addrW  = vecs[t].caddr;
         core_dataW  = vecs[t].cdata;
         host_valid  = vecs[t].hvalid;
         host_addr   = vecs[t].haddr;
         host_data   = vecs[t].hdata;
         #1;
         act = {13'd0, core_start, busy, frame_done, mem_we, host_ready,
                (vecs[t].e_we ? mem_addrW : 10'd0), (vecs[t].e_we ? mem_dataW : 36'd0)};
         exp = {13'd0, vecs[t].e_start, vecs[t].e_busy, vecs[t].e_done, vecs[t].e_we,
                vecs[t].e_ready, vecs[t].e_addr, vecs[t].e_data};
         chk($sformatf("vec[%0d]", t), act, exp);
         cyc();
      end
      idle_inputs();
      #1;
      chk("no_overrun_single_pass", 64'(overrun_cnt), 64'd0);

      // ---------------- ticks at 0,3,6 ----------------
      fd = 0;
      ok = 1'b1;
      for (int t = 0; t < 40; t++) begin
         sample_tick = (t == 0 || t == 3 || t == 6);
         #1;
         if (frame_done) fd++;
         if (t == 13 && core_start !== 1'b1) ok = 1'b0;
         if (t == 14 && core_start !== 1'b0) ok = 1'b0;
         cyc();
      end
      sample_tick = 1'b0;
      chk("pending_pass_start_t14", 64'(ok), 64'd1);
      chk("frame_done_pulses_a", 64'(fd), 64'd2);
      chk("overrun_after_3_ticks", 64'(overrun_cnt), 64'd1);

      // ---------------- tick in the IDLE cycle that consumes pending ----------------
      fd = 0;
      for (int t = 0; t < 40; t++) begin
         sample_tick = (t == 0 || t == 3 || t == 13);
         #1;
         if (frame_done) fd++;
         cyc();
      end
      sample_tick = 1'b0;
      chk("frame_done_pulses_b", 64'(fd), 64'd2);
      chk("overrun_consume_cycle", 64'(overrun_cnt), 64'd2);

      // ---------------- reset mid-pass with FIFO entries ----------------
      for (int t = 0; t < 5; t++) begin
         sample_tick = (t == 0);
         host_valid  = (t == 2 || t == 3);
         host_addr   = (t == 2) ? 10'h0AA : 10'h0BB;
         host_data   = 36'h3_0000_0000 + 36'(t);
         cyc();
      end
      idle_inputs();
      // t=5: RUN with cnt=4, two queued host writes
      #1;
      chk("busy_before_rst", 64'({busy, core_start}), 64'b10);
      rst = 1'b1;
      #1;
      chk("async_rst_state",
          {43'd0, core_start, busy, frame_done, mem_we, host_ready, overrun_cnt},
          {43'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0});
      cyc();
      cyc();
      rst = 1'b0;
      ok = 1'b1;
      for (int t = 0; t < 5; t++) begin
         #1;
         if (mem_we !== 1'b0 || core_start !== 1'b1 || busy !== 1'b0) ok = 1'b0;
         cyc();
      end
      chk("fifo_flushed_no_we", 64'(ok), 64'd1);
      host_valid = 1'b1;
      host_addr  = 10'h055;
      host_data  = 36'h9_8765_4321;
      cyc();
      idle_inputs();
      #1;
      chk("post_rst_host_write", {17'd0, mem_we, mem_addrW, mem_dataW},
          {17'd0, 1'b1, 10'h055, 36'h9_8765_4321});
      cyc();
      #1;
      chk("post_rst_single_drain", 64'(mem_we), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
